counter_cmd_sched: RTL

//  Command scheduler for the mod-12 up/down counter (counter: clk, reset, load, mode, data_in, data_out).

---
 rtl/counter_cmd_sched_if.sv | 28 ++
 rtl/counter_cmd_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sched_if.sv
// rtl/counter_cmd_sched_if.sv - requester command/response bundle for counter_cmd_sched
interface counter_cmd_sched_if #(
  parameter int NREQ   = 2,
  parameter int CW     = 4,
  parameter int STEP_W = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [NREQ*STEP_W-1:0] req_arg;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [CW-1:0]          rsp_data;

  // Requesters drive commands and sample the completion pulse.
  modport master (
    output req_valid, req_op, req_arg,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // The scheduler accepts commands and returns completions.
  modport slave (
    input  req_valid, req_op, req_arg,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/counter_cmd_sched.sv
// rtl/counter_cmd_sched.sv - round-robin command scheduler for a mod-MODULUS up/down counter (optional COUNTER_CMD_SCHED_CHECK_EN model check)
module counter_cmd_sched #(
  parameter int NREQ    = 2,
  parameter int CW      = 4,
  parameter int MODULUS = 12,
  parameter int STEP_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  counter_cmd_sched_if.slave     bus,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   cnt_load_o,
  output logic                   cnt_mode_o,
  output logic [CW-1:0]          cnt_data_in_o,
  input  logic [CW-1:0]          cnt_data_out_i
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              up_q, up_d;
  logic [CW-1:0]     load_val_q, load_val_d;
  logic [STEP_W-1:0] steps_q, steps_d;

  logic              grant_vld;
  logic [IDW-1:0]    grant_idx;
  logic [1:0]        grant_op;
  logic [STEP_W-1:0] grant_arg;

  // Requester index base+offs, wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && bus.req_valid[rr_idx(ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(ptr_q, i);
      end
    end
    grant_op  = bus.req_op[int'(grant_idx)*2 +: 2];
    grant_arg = bus.req_arg[int'(grant_idx)*STEP_W +: STEP_W];
  end

  // Ready only to the granted requester while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (!reset_i && state_q == S_IDLE && grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

  // Next-state: command capture on accept, step countdown in RUN.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    up_d       = up_q;
    load_val_d = load_val_q;
    steps_d    = steps_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          id_d       = grant_idx;
          ptr_d      = rr_idx(grant_idx, 1);
          up_d       = (grant_op == OP_UP);
          steps_d    = grant_arg;
          load_val_d = (grant_op == OP_CLEAR) ? '0 : grant_arg[CW-1:0];
          if (grant_op == OP_LOAD || grant_op == OP_CLEAR) state_d = S_LOAD;
          else if (grant_arg == '0)                        state_d = S_DONE;
          else                                             state_d = S_RUN;
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN: begin
        steps_d = steps_q - 1'b1;
        if (steps_q == STEP_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any command in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      up_q       <= 1'b0;
      load_val_q <= '0;
      steps_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      up_q       <= up_d;
      load_val_q <= load_val_d;
      steps_q    <= steps_d;
    end
  end

  // Counter pins: hold by loop-back except in LOAD and RUN; reset loads zero.
  always_comb begin
    cnt_load_o    = 1'b1;
    cnt_mode_o    = 1'b0;
    cnt_data_in_o = cnt_data_out_i;
    if (reset_i) begin
      cnt_data_in_o = '0;
    end else if (state_q == S_LOAD) begin
      cnt_data_in_o = load_val_q;
    end else if (state_q == S_RUN) begin
      cnt_load_o = 1'b0;
      cnt_mode_o = up_q;
    end
  end

  // Completion pulse and status.
  always_comb begin
    bus.rsp_valid = !reset_i && (state_q == S_DONE);
    bus.rsp_id    = bus.rsp_valid ? id_q : '0;
    bus.rsp_data  = bus.rsp_valid ? cnt_data_out_i : '0;
    busy_o        = !reset_i && (state_q != S_IDLE);
  end

`ifdef COUNTER_CMD_SCHED_CHECK_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MODULUS - 1);

  logic [CW-1:0] model_q, model_d;
  logic          model_vld_q, model_vld_d;
  logic          err_q, err_d;

  // Shadow count tracked from the commands; compared against the counter at completion.
  always_comb begin
    model_d     = model_q;
    model_vld_d = model_vld_q;
    err_d       = err_q;
    case (state_q)
      S_LOAD: begin
        model_d     = load_val_q;
        model_vld_d = 1'b1;
      end
      S_RUN: begin
        if (up_q) model_d = (model_q == CNT_MAX) ? '0 : model_q + 1'b1;
        else      model_d = (model_q == '0) ? CNT_MAX : model_q - 1'b1;
      end
      S_DONE: begin
        if (model_vld_q && model_q != cnt_data_out_i) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Model and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      model_q     <= '0;
      model_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      model_q     <= model_d;
      model_vld_q <= model_vld_d;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule
